// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
//
// Phase sequencer for the in-place FFT datapath. A frame walks through three
// phases that steer the butterfly core's operand mux:
//   BUF  (sel_sig=0) for BUF_LEN cycles
//   IN   (sel_sig=1) for IN_LEN cycles
//   MEM  (sel_sig=2) for MEM_LEN cycles, repeated STAGES times
// After the last MEM stage the block either returns to IDLE or, when cont is
// high, starts the next frame in BUF with no gap cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a frame (only looked at in IDLE)
//   cont       in   continuous mode (only looked at on the final frame cycle)
//   stall      in   freeze state and counters; frame_done is suppressed
//   abort      in   synchronous return to IDLE, highest priority
//   sel_sig    out  [1:0] mux select: 0 buffer/none, 1 input, 2 memory
//   phase_cnt  out  [CNT_W-1:0] cycle index inside the current phase
//   stage_idx  out  [STG_W-1:0] memory stage, 0 outside MEM
//   busy       out  high in any state other than IDLE
//   frame_done out  one-cycle pulse on the final (unstalled) cycle of a frame
//
// sel_sig, busy and frame_done are decoded combinationally from the state
// registers (and stall/abort for frame_done) so they line up with the
// datapath in the same cycle.
// -----------------------------------------------------------------------------
module fft_seq_ctrl #(
    parameter int BUF_LEN = 2,
    parameter int IN_LEN  = 2,
    parameter int MEM_LEN = 2,
    parameter int STAGES  = 2,
    parameter int CNT_W   = 4,
    parameter int STG_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             stall,
    input  logic             abort,
    output logic [1:0]       sel_sig,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [STG_W-1:0] stage_idx,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUF  = 2'd1,
        ST_IN   = 2'd2,
        ST_MEM  = 2'd3
    } state_e;

    // Terminal counter values; a length of 1 makes the terminal value 0.
    localparam logic [CNT_W-1:0] BUF_LAST = CNT_W'(BUF_LEN - 1);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_LEN - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LEN - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic             final_s;

    // Last cycle of the last memory stage, before stall/abort qualification.
    assign final_s = (state_q == ST_MEM) && (cnt_q == MEM_LAST) && (stg_q == STG_LAST);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            stg_q   <= {STG_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
        end
    end

    // Next-state logic: abort beats everything, stall freezes only non-IDLE states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            stg_d   = {STG_W{1'b0}};
        end else if (stall && (state_q != ST_IDLE)) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_BUF;
                        cnt_d   = {CNT_W{1'b0}};
                        stg_d   = {STG_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUF: begin
                    if (cnt_q == BUF_LAST) begin
                        state_d = ST_IN;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_IN: begin
                    if (cnt_q == IN_LAST) begin
                        state_d = ST_MEM;
                        cnt_d   = {CNT_W{1'b0}};
                        stg_d   = {STG_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_MEM: begin
                    if (cnt_q == MEM_LAST) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (stg_q == STG_LAST) begin
                            // Frame end: back-to-back frame in continuous mode.
                            stg_d   = {STG_W{1'b0}};
                            state_d = cont ? ST_BUF : ST_IDLE;
                        end else begin
                            stg_d   = stg_q + STG_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    stg_d   = {STG_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        sel_sig = 2'd0;
        busy    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                sel_sig = 2'd0;
                busy    = 1'b0;
            end
            ST_BUF:  sel_sig = 2'd0;
            ST_IN:   sel_sig = 2'd1;
            ST_MEM:  sel_sig = 2'd2;
            default: begin
                sel_sig = 2'd0;
                busy    = 1'b0;
            end
        endcase
    end

    assign phase_cnt  = cnt_q;
    assign stage_idx  = stg_q;
    assign frame_done = final_s && !stall && !abort;

endmodule
